// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: walks a trial code MSB->LSB against a comparator
// and hands the final code over valid/ready. Optional clip flag/counter: SAR_ADC_CLIP_FLAG_EN.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             cmp_i,
    output logic [WIDTH-1:0] dac_code_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    input  logic             result_ready_i
`ifdef SAR_ADC_CLIP_FLAG_EN
    ,
    output logic             clip_o,
    output logic [7:0]       clip_count_o
`endif
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("sar_adc_ctrl: WIDTH must be in 2..16");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("sar_adc_ctrl: SETTLE_CYCLES must be in 1..15");
    end

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(WIDTH - 1);
    localparam logic [3:0]       RELOAD  = 4'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MSB     = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] trial;
    logic             decision;

`ifdef SAR_ADC_CLIP_FLAG_EN
    logic             clip_q, clip_d;
    logic [7:0]       clip_cnt_q, clip_cnt_d;
`endif

    assign decision = (state_q == SETTLE) && (cnt_q == 4'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            dac_q      <= '0;
            idx_q      <= IDX_TOP;
            cnt_q      <= 4'd0;
            result_q   <= '0;
            valid_q    <= 1'b0;
`ifdef SAR_ADC_CLIP_FLAG_EN
            clip_q     <= 1'b0;
            clip_cnt_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            dac_q      <= dac_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
`ifdef SAR_ADC_CLIP_FLAG_EN
            clip_q     <= clip_d;
            clip_cnt_q <= clip_cnt_d;
`endif
        end
    end

    // The trial bit under test is already 1, so writing cmp into it keeps or clears it.
    always_comb begin
        state_d  = state_q;
        dac_d    = dac_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = valid_q;
        trial    = dac_q;
`ifdef SAR_ADC_CLIP_FLAG_EN
        clip_d     = clip_q;
        clip_cnt_d = clip_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                dac_d = '0;
                if (start_i) begin
                    state_d = SETTLE;
                    dac_d   = MSB;
                    idx_d   = IDX_TOP;
                    cnt_d   = RELOAD;
                end
            end

            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    trial[idx_q] = cmp_i;
                    if (idx_q != '0) begin
                        trial[idx_q - 1'b1] = 1'b1;
                        idx_d = idx_q - 1'b1;
                        cnt_d = RELOAD;
                        dac_d = trial;
                    end else begin
                        dac_d    = trial;
                        result_d = trial;
                        valid_d  = 1'b1;
                        state_d  = DONE;
`ifdef SAR_ADC_CLIP_FLAG_EN
                        if (trial == '0 || trial == '1) begin
                            clip_d = 1'b1;
                            if (clip_cnt_q != 8'hFF) begin
                                clip_cnt_d = clip_cnt_q + 8'd1;
                            end
                        end
`endif
                    end
                end
            end

            DONE: begin
                if (result_ready_i) begin
                    valid_d = 1'b0;
                    dac_d   = '0;
                    state_d = IDLE;
`ifdef SAR_ADC_CLIP_FLAG_EN
                    clip_d  = 1'b0;
`endif
                end
            end

            default: begin
                state_d = IDLE;
                dac_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign dac_code_o     = dac_q;
    assign busy_o         = (state_q != IDLE);
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
`ifdef SAR_ADC_CLIP_FLAG_EN
    assign clip_o         = clip_q;
    assign clip_count_o   = clip_cnt_q;
`endif

`ifndef SYNTHESIS
    // An undriven comparator at a decision would silently corrupt the result bit.
    assert property (@(posedge clk_i) disable iff (rst_i) decision |-> !$isunknown(cmp_i));
`endif

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: an ideal 4 V full-scale comparator model drives cmp;
// a second instance with SETTLE_CYCLES=1 covers the short-settle back-to-back case.
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic       ready, ready2;
    logic       cmp, cmp2;
    logic [7:0] dac, dac2, result, result2;
    logic       busy, busy2, rv, rv2;
    real        vin, vin2;
    int         nCompared   = 0;
    int         nMismatched = 0;

`ifdef SAR_ADC_CLIP_FLAG_EN
    logic       clip, clip2;
    logic [7:0] clipCount, clipCount2;
`endif

    always #5 clk = ~clk;

    assign cmp  = (vin  >= real'(dac)  * 4.0 / 256.0);
    assign cmp2 = (vin2 >= real'(dac2) * 4.0 / 256.0);

    sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cmp_i(cmp),
        .dac_code_o(dac), .busy_o(busy), .result_o(result),
        .result_valid_o(rv), .result_ready_i(ready)
`ifdef SAR_ADC_CLIP_FLAG_EN
        , .clip_o(clip), .clip_count_o(clipCount)
`endif
    );

    sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .cmp_i(cmp2),
        .dac_code_o(dac2), .busy_o(busy2), .result_o(result2),
        .result_valid_o(rv2), .result_ready_i(ready2)
`ifdef SAR_ADC_CLIP_FLAG_EN
        , .clip_o(clip2), .clip_count_o(clipCount2)
`endif
    );

    // Pulse start for one cycle and wait (bounded) until result_valid is seen.
    task automatic run_conv(input real v, output int cycles, output logic [7:0] res);
        vin = v;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (!rv && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        res = result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        nCompared += 5;
        if (busy !== 1'b0)   begin nMismatched++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
        if (dac !== 8'd0)    begin nMismatched++; $display("[TB] FAIL reset_dac: got %0d, expected 0", dac); end
        if (rv !== 1'b0)     begin nMismatched++; $display("[TB] FAIL reset_valid: got %0b, expected 0", rv); end
        if (result !== 8'd0) begin nMismatched++; $display("[TB] FAIL reset_result: got %0d, expected 0", result); end
        if (busy2 !== 1'b0)  begin nMismatched++; $display("[TB] FAIL reset_busy2: got %0b, expected 0", busy2); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] expSeq [8];
        expSeq = '{8'd128, 8'd192, 8'd224, 8'd208, 8'd200, 8'd196, 8'd194, 8'd193};
        vin = 3.0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start = 1'b0;
            nCompared += 2;
            if (dac !== expSeq[(k-1)/2]) begin
                nMismatched++;
                $display("[TB] FAIL dac_seq[%0d]: got %0d, expected %0d", k, dac, expSeq[(k-1)/2]);
            end
            if (rv !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL early_valid[%0d]: got %0b, expected 0", k, rv);
            end
        end
        @(negedge clk);
        nCompared += 3;
        if (rv !== 1'b1)      begin nMismatched++; $display("[TB] FAIL valid_at_17: got %0b, expected 1", rv); end
        if (result !== 8'd192) begin nMismatched++; $display("[TB] FAIL result_3v0: got %0d, expected 192", result); end
        if (dac !== 8'd192)    begin nMismatched++; $display("[TB] FAIL dac_done: got %0d, expected 192", dac); end
        @(negedge clk);
        nCompared += 3;
        if (rv !== 1'b0)   begin nMismatched++; $display("[TB] FAIL valid_one_cycle: got %0b, expected 0", rv); end
        if (dac !== 8'd0)  begin nMismatched++; $display("[TB] FAIL dac_idle: got %0d, expected 0", dac); end
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL busy_idle: got %0b, expected 0", busy); end
    endtask

    task automatic test_sweep();
        real        vins [3];
        logic [7:0] exps [3];
        logic       expClip [3];
        int         cyc;
        logic [7:0] res;
        vins    = '{2.0, 0.0, 4.0};
        exps    = '{8'd128, 8'd0, 8'd255};
        expClip = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_conv(vins[i], cyc, res);
            nCompared += 2;
            if (cyc !== 17) begin nMismatched++; $display("[TB] FAIL sweep_latency[%0d]: got %0d, expected 17", i, cyc); end
            if (res !== exps[i]) begin nMismatched++; $display("[TB] FAIL sweep_result[%0d]: got %0d, expected %0d", i, res, exps[i]); end
`ifdef SAR_ADC_CLIP_FLAG_EN
            nCompared++;
            if (clip !== expClip[i]) begin nMismatched++; $display("[TB] FAIL clip[%0d]: got %0b, expected %0b", i, clip, expClip[i]); end
`endif
            @(negedge clk);
        end
`ifdef SAR_ADC_CLIP_FLAG_EN
        nCompared += 2;
        if (clipCount !== 8'd2) begin nMismatched++; $display("[TB] FAIL clip_count: got %0d, expected 2", clipCount); end
        if (clip !== 1'b0)      begin nMismatched++; $display("[TB] FAIL clip_cleared: got %0b, expected 0", clip); end
`endif
    endtask

    task automatic test_stall();
        int         cyc;
        logic [7:0] res;
        ready = 1'b0;
        run_conv(1.5, cyc, res);
        nCompared += 2;
        if (cyc !== 17)     begin nMismatched++; $display("[TB] FAIL stall_latency: got %0d, expected 17", cyc); end
        if (res !== 8'd96)  begin nMismatched++; $display("[TB] FAIL stall_result: got %0d, expected 96", res); end
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(negedge clk);
            nCompared += 3;
            if (rv !== 1'b1)      begin nMismatched++; $display("[TB] FAIL stall_valid[%0d]: got %0b, expected 1", i, rv); end
            if (result !== 8'd96) begin nMismatched++; $display("[TB] FAIL stall_hold[%0d]: got %0d, expected 96", i, result); end
            if (busy !== 1'b1)    begin nMismatched++; $display("[TB] FAIL stall_busy[%0d]: got %0b, expected 1", i, busy); end
        end
        start = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        nCompared += 3;
        if (rv !== 1'b0)   begin nMismatched++; $display("[TB] FAIL release_valid: got %0b, expected 0", rv); end
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL release_busy: got %0b, expected 0", busy); end
        if (dac !== 8'd0)  begin nMismatched++; $display("[TB] FAIL release_dac: got %0d, expected 0", dac); end
        repeat (2) @(negedge clk);
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL start_not_queued: got %0b, expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int         cyc;
        logic [7:0] res;
        vin = 1.0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nCompared += 3;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_busy: got %0b, expected 0", busy); end
        if (dac !== 8'd0)  begin nMismatched++; $display("[TB] FAIL midrst_dac: got %0d, expected 0", dac); end
        if (rv !== 1'b0)   begin nMismatched++; $display("[TB] FAIL midrst_valid: got %0b, expected 0", rv); end
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        nCompared++;
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_beats_start: got %0b, expected 0", busy); end
        run_conv(1.0, cyc, res);
        nCompared += 2;
        if (cyc !== 17)    begin nMismatched++; $display("[TB] FAIL fresh_latency: got %0d, expected 17", cyc); end
        if (res !== 8'd64) begin nMismatched++; $display("[TB] FAIL fresh_result: got %0d, expected 64", res); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int nConv  = 0;
        int firstK = 0;
        int prevK  = 0;
        vin2   = 2.5;
        ready2 = 1'b1;
        @(negedge clk);
        start2 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rv2) begin
                nConv++;
                nCompared++;
                if (result2 !== 8'd160) begin nMismatched++; $display("[TB] FAIL b2b_result[%0d]: got %0d, expected 160", k, result2); end
                if (firstK == 0) begin
                    firstK = k;
                end else begin
                    nCompared++;
                    if (k - prevK !== 10) begin nMismatched++; $display("[TB] FAIL b2b_period: got %0d, expected 10", k - prevK); end
                end
                prevK = k;
            end
        end
        start2 = 1'b0;
        nCompared += 2;
        if (firstK !== 9) begin nMismatched++; $display("[TB] FAIL b2b_latency: got %0d, expected 9", firstK); end
        if (nConv !== 4)  begin nMismatched++; $display("[TB] FAIL b2b_count: got %0d, expected 4", nConv); end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        ready  = 1'b1;
        ready2 = 1'b1;
        vin    = 0.0;
        vin2   = 0.0;
        test_reset();
        test_single();
        test_sweep();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
